// File: rtl/trig_sequencer.sv
// rtl/trig_sequencer.sv - internal/external event source with round-robin multi-channel transmit pulse sequencer
module trig_sequencer #(
  parameter  int CH_NUM      = 4,
  parameter  int CYCLE_W     = 20,
  parameter  int DELAY_W     = 16,
  parameter  int PULSE_W     = 12,
  parameter  int SYNC_STAGES = 2,
  localparam int IDX_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic               i_clk100M,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_outmode,
  input  logic               i_outnegedge,
  input  logic               i_trig,
  input  logic [CYCLE_W-1:0] i_cycle,
  input  logic [DELAY_W-1:0] i_outdelay,
  input  logic [DELAY_W-1:0] i_wavedelay,
  input  logic [PULSE_W-1:0] i_pulse,
  input  logic [CH_NUM-1:0]  i_ch_mask,
  output logic [CH_NUM-1:0]  o_trig,
  output logic               o_st,
  output logic [IDX_W-1:0]   o_ch_idx,
  output logic               o_busy,
  output logic               o_overrun
);

  typedef enum logic [1:0] {IDLE, WDELAY, PULSE} state_t;

  state_t             state_q, state_n;
  logic               mode_q;
  logic               abort;
  logic [CYCLE_W-1:0] cnt_q;
  logic               int_active, int_event;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               sync_last, prev_q, det_q;
  logic               dly_active_q;
  logic [DELAY_W-1:0] dly_cnt_q;
  logic               ext_event, ext_drop, seq_event;
  logic [DELAY_W-1:0] wcnt_q, wcnt_n;
  logic [PULSE_W-1:0] pcnt_q, pcnt_n, plen_q, plen_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n, ch_n, sel;
  logic               sel_found, st_n, ovr_n;
  logic [CH_NUM-1:0]  trig_n;

  // A mode change is treated like a disable for one cycle so no stale countdown leaks across sources
  assign abort      = !i_en || (i_outmode != mode_q);
  assign int_active = i_en && !i_outmode && (i_cycle != '0);
  assign int_event  = int_active && (cnt_q == i_cycle - CYCLE_W'(1));
  assign sync_last  = sync_q[SYNC_STAGES-1];
  assign ext_drop   = det_q && dly_active_q;
  assign ext_event  = (det_q && !dly_active_q && (i_outdelay == '0)) ||
                      (dly_active_q && (dly_cnt_q == '0));
  assign seq_event  = !abort && (int_event || ext_event);
  assign o_busy     = (state_q != IDLE);

  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      det_q        <= 1'b0;
      dly_active_q <= 1'b0;
      dly_cnt_q    <= '0;
    end else begin
      mode_q <= i_outmode;
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_trig};
      prev_q <= sync_last;
      det_q  <= i_en && i_outmode &&
                (i_outnegedge ? (!sync_last && prev_q) : (sync_last && !prev_q));
      if (!int_active || abort || int_event)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CYCLE_W'(1);
      if (abort) begin
        dly_active_q <= 1'b0;
        dly_cnt_q    <= '0;
      end else if (dly_active_q) begin
        if (dly_cnt_q == '0)
          dly_active_q <= 1'b0;
        else
          dly_cnt_q <= dly_cnt_q - DELAY_W'(1);
      end else if (det_q && (i_outdelay != '0)) begin
        dly_active_q <= 1'b1;
        dly_cnt_q    <= i_outdelay - DELAY_W'(1);
      end
    end
  end

  // Round-robin: lowest enabled channel above the pointer, else wrap to the lowest enabled one
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (i_ch_mask[i] && (i > int'(ptr_q))) begin
        sel       = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
    if (!sel_found) begin
      for (int i = CH_NUM - 1; i >= 0; i--) begin
        if (i_ch_mask[i])
          sel = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_n = state_q;
    wcnt_n  = wcnt_q;
    pcnt_n  = pcnt_q;
    plen_n  = plen_q;
    ptr_n   = ptr_q;
    ch_n    = o_ch_idx;
    st_n    = 1'b0;
    ovr_n   = !abort && ((seq_event && (state_q != IDLE)) || ext_drop);
    case (state_q)
      IDLE: begin
        if (seq_event && (i_ch_mask != '0)) begin
          st_n   = 1'b1;
          ch_n   = sel;
          ptr_n  = sel;
          plen_n = i_pulse;
          if (i_wavedelay != '0) begin
            state_n = WDELAY;
            wcnt_n  = i_wavedelay - DELAY_W'(1);
          end else if (i_pulse != '0) begin
            state_n = PULSE;
            pcnt_n  = i_pulse - PULSE_W'(1);
          end
        end
      end
      WDELAY: begin
        if (wcnt_q != '0) begin
          wcnt_n = wcnt_q - DELAY_W'(1);
        end else if (plen_q != '0) begin
          state_n = PULSE;
          pcnt_n  = plen_q - PULSE_W'(1);
        end else begin
          state_n = IDLE;
        end
      end
      PULSE: begin
        if (pcnt_q == '0)
          state_n = IDLE;
        else
          pcnt_n = pcnt_q - PULSE_W'(1);
      end
      default: state_n = IDLE;
    endcase
    if (abort)
      state_n = IDLE;
    trig_n = '0;
    if (state_n == PULSE)
      trig_n[ch_n] = 1'b1;
  end

  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      plen_q    <= '0;
      ptr_q     <= IDX_W'(CH_NUM - 1);
      o_ch_idx  <= '0;
      o_st      <= 1'b0;
      o_trig    <= '0;
      o_overrun <= 1'b0;
    end else begin
      state_q   <= state_n;
      wcnt_q    <= wcnt_n;
      pcnt_q    <= pcnt_n;
      plen_q    <= plen_n;
      ptr_q     <= ptr_n;
      o_ch_idx  <= ch_n;
      o_st      <= st_n;
      o_trig    <= trig_n;
      o_overrun <= ovr_n;
    end
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// tb/tb_trig_sequencer.sv - scoreboard bench for trig_sequencer
module tb_trig_sequencer;
  localparam int CH_NUM = 4, CYCLE_W = 20, DELAY_W = 16, PULSE_W = 12, SYNC_STAGES = 2;

  typedef struct { int cyc; int ch; } st_exp_t;
  typedef struct { int cyc; logic [CH_NUM-1:0] val; int len; } trig_exp_t;

  logic               i_clk100M = 1'b0;
  logic               i_rst_n;
  logic               i_en, i_outmode, i_outnegedge, i_trig;
  logic [CYCLE_W-1:0] i_cycle;
  logic [DELAY_W-1:0] i_outdelay, i_wavedelay;
  logic [PULSE_W-1:0] i_pulse;
  logic [CH_NUM-1:0]  i_ch_mask;
  logic [CH_NUM-1:0]  o_trig;
  logic               o_st, o_busy, o_overrun;
  logic [1:0]         o_ch_idx;

  st_exp_t   st_q[$];
  trig_exp_t trig_q[$];
  int        ovr_q[$];
  int        n_checks = 0, n_fail = 0, cyc = 0;
  logic [CH_NUM-1:0] trig_prev = '0, trig_val = '0;
  int        trig_start = 0;

  trig_sequencer #(.CH_NUM(CH_NUM), .CYCLE_W(CYCLE_W), .DELAY_W(DELAY_W),
                   .PULSE_W(PULSE_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk100M(i_clk100M), .i_rst_n(i_rst_n), .i_en(i_en), .i_outmode(i_outmode),
    .i_outnegedge(i_outnegedge), .i_trig(i_trig), .i_cycle(i_cycle),
    .i_outdelay(i_outdelay), .i_wavedelay(i_wavedelay), .i_pulse(i_pulse),
    .i_ch_mask(i_ch_mask), .o_trig(o_trig), .o_st(o_st), .o_ch_idx(o_ch_idx),
    .o_busy(o_busy), .o_overrun(o_overrun));

  always #5 i_clk100M = ~i_clk100M;

  // Advance one clock, sampling on the falling edge and scoring any produced output
  task automatic step();
    st_exp_t   se;
    trig_exp_t te;
    int        oc;
    @(negedge i_clk100M);
    cyc++;
    if (!i_rst_n) begin
      trig_prev = '0;
    end else begin
      if (o_st) begin
        n_checks++;
        if (st_q.size() == 0) begin
          n_fail++;
          $display("FAIL st_unexpected: o_st at cyc %0d ch %0d, expected none", cyc, o_ch_idx);
        end else begin
          se = st_q.pop_front();
          if (se.cyc !== cyc || se.ch !== int'(o_ch_idx)) begin
            n_fail++;
            $display("FAIL st_event: got cyc %0d ch %0d, expected cyc %0d ch %0d", cyc, o_ch_idx, se.cyc, se.ch);
          end
        end
      end
      if (o_overrun) begin
        n_checks++;
        if (ovr_q.size() == 0) begin
          n_fail++;
          $display("FAIL overrun_unexpected: o_overrun at cyc %0d, expected none", cyc);
        end else begin
          oc = ovr_q.pop_front();
          if (oc !== cyc) begin
            n_fail++;
            $display("FAIL overrun_event: got cyc %0d, expected cyc %0d", cyc, oc);
          end
        end
      end
      if (o_trig != '0 && trig_prev == '0) begin
        trig_start = cyc;
        trig_val   = o_trig;
      end else if (o_trig == '0 && trig_prev != '0) begin
        n_checks++;
        if (trig_q.size() == 0) begin
          n_fail++;
          $display("FAIL trig_unexpected: pulse %b at cyc %0d len %0d, expected none", trig_val, trig_start, cyc - trig_start);
        end else begin
          te = trig_q.pop_front();
          if (te.cyc !== trig_start || te.val !== trig_val || te.len !== cyc - trig_start) begin
            n_fail++;
            $display("FAIL trig_pulse: got %b at cyc %0d len %0d, expected %b at cyc %0d len %0d",
                     trig_val, trig_start, cyc - trig_start, te.val, te.cyc, te.len);
          end
        end
      end
      trig_prev = o_trig;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_st(input int c, input int ch);
    st_q.push_back('{cyc: c, ch: ch});
  endtask

  task automatic push_trig(input int c, input int ch, input int len);
    logic [CH_NUM-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    trig_q.push_back('{cyc: c, val: v, len: len});
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_en = 1'b0; i_outmode = 1'b0; i_outnegedge = 1'b0; i_trig = 1'b0;
    i_cycle = '0; i_outdelay = '0; i_wavedelay = '0; i_pulse = '0; i_ch_mask = '0;
    repeat (3) step();
    n_checks++; if (o_trig !== '0)    begin n_fail++; $display("FAIL reset_trig: got %b, expected 0", o_trig); end
    n_checks++; if (o_st !== 1'b0)    begin n_fail++; $display("FAIL reset_st: got %b, expected 0", o_st); end
    n_checks++; if (o_ch_idx !== '0)  begin n_fail++; $display("FAIL reset_ch_idx: got %0d, expected 0", o_ch_idx); end
    n_checks++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", o_overrun); end
    i_rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_internal();
    int n;
    i_cycle = 1000; i_wavedelay = 10; i_pulse = 50; i_ch_mask = 4'b1111; i_outmode = 1'b0;
    n = cyc; i_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push_st(n + 1000 * k, (k - 1) % 4);
      push_trig(n + 1000 * k + 10, (k - 1) % 4, 50);
    end
    wait_until(n + 1005);
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL internal_busy_wdelay: got %b, expected 1", o_busy); end
    wait_until(n + 1070);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL internal_busy_idle: got %b, expected 0", o_busy); end
    wait_until(n + 5070);
    i_en = 1'b0; step();
    n_checks++;
    if (st_q.size() + trig_q.size() + ovr_q.size() != 0) begin
      n_fail++; $display("FAIL internal_drain: pending %0d/%0d/%0d, expected 0/0/0", st_q.size(), trig_q.size(), ovr_q.size());
    end
    st_q.delete(); trig_q.delete(); ovr_q.delete();
  endtask

  task automatic test_mask_alternate();
    int n;
    i_cycle = 200; i_wavedelay = 0; i_pulse = 5; i_ch_mask = 4'b1010;
    n = cyc; i_en = 1'b1;
    push_st(n + 200, 1); push_trig(n + 200, 1, 5);
    push_st(n + 400, 3); push_trig(n + 400, 3, 5);
    push_st(n + 600, 1); push_trig(n + 600, 1, 5);
    wait_until(n + 610);
    i_en = 1'b0; step();
    n_checks++;
    if (st_q.size() + trig_q.size() + ovr_q.size() != 0) begin
      n_fail++; $display("FAIL mask_drain: pending %0d/%0d/%0d, expected 0/0/0", st_q.size(), trig_q.size(), ovr_q.size());
    end
    st_q.delete(); trig_q.delete(); ovr_q.delete();
  endtask

  task automatic test_external();
    int p, r, q;
    i_outmode = 1'b1; i_outdelay = 25; i_outnegedge = 1'b0; i_wavedelay = 3; i_pulse = 4;
    i_ch_mask = 4'b1111; i_trig = 1'b0;
    step();
    i_en = 1'b1;
    repeat (5) step();
    p = cyc; i_trig = 1'b1;
    push_st(p + SYNC_STAGES + 1 + 25 + 1, 2);
    push_trig(p + SYNC_STAGES + 1 + 25 + 1 + 3, 2, 4);
    ovr_q.push_back(p + 14);
    wait_until(p + 5);  i_trig = 1'b0;
    wait_until(p + 10); i_trig = 1'b1;
    wait_until(p + 60); i_trig = 1'b0;
    wait_until(p + 100);
    i_outnegedge = 1'b1;
    wait_until(p + 110);
    r = cyc; i_trig = 1'b1;
    wait_until(r + 40);
    q = cyc; i_trig = 1'b0;
    push_st(q + 29, 3); push_trig(q + 32, 3, 4);
    wait_until(q + 60);
    i_en = 1'b0; step();
    i_outmode = 1'b0; i_outnegedge = 1'b0; step();
    n_checks++;
    if (st_q.size() + trig_q.size() + ovr_q.size() != 0) begin
      n_fail++; $display("FAIL external_drain: pending %0d/%0d/%0d, expected 0/0/0", st_q.size(), trig_q.size(), ovr_q.size());
    end
    st_q.delete(); trig_q.delete(); ovr_q.delete();
  endtask

  task automatic test_overrun();
    int n;
    i_cycle = 100; i_wavedelay = 80; i_pulse = 40; i_ch_mask = 4'b1111;
    n = cyc; i_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_st(n + 100 + 200 * k, k);
      push_trig(n + 180 + 200 * k, k, 40);
      ovr_q.push_back(n + 200 + 200 * k);
    end
    wait_until(n + 630);
    i_en = 1'b0; step();
    n_checks++;
    if (st_q.size() + trig_q.size() + ovr_q.size() != 0) begin
      n_fail++; $display("FAIL overrun_drain: pending %0d/%0d/%0d, expected 0/0/0", st_q.size(), trig_q.size(), ovr_q.size());
    end
    st_q.delete(); trig_q.delete(); ovr_q.delete();
  endtask

  task automatic test_abort();
    int n, m;
    i_cycle = 100; i_wavedelay = 5; i_pulse = 50; i_ch_mask = 4'b1111;
    n = cyc; i_en = 1'b1;
    push_st(n + 100, 3); push_trig(n + 105, 3, 16);
    wait_until(n + 120);
    i_en = 1'b0; step();
    n_checks++; if (o_trig !== '0)   begin n_fail++; $display("FAIL abort_trig: got %b, expected 0", o_trig); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, expected 0", o_busy); end
    wait_until(n + 420);
    m = cyc; i_en = 1'b1;
    push_st(m + 100, 0); push_trig(m + 105, 0, 50);
    wait_until(m + 160);
    i_en = 1'b0; step();
    n_checks++;
    if (st_q.size() + trig_q.size() + ovr_q.size() != 0) begin
      n_fail++; $display("FAIL abort_drain: pending %0d/%0d/%0d, expected 0/0/0", st_q.size(), trig_q.size(), ovr_q.size());
    end
    st_q.delete(); trig_q.delete(); ovr_q.delete();
  endtask

  task automatic test_edges();
    int n;
    i_cycle = 100; i_wavedelay = 10; i_pulse = 0; i_ch_mask = 4'b1111;
    n = cyc; i_en = 1'b1;
    push_st(n + 100, 1);
    wait_until(n + 109);
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL pulse0_busy_end: got %b, expected 1", o_busy); end
    step();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL pulse0_idle: got %b, expected 0", o_busy); end
    wait_until(n + 150);
    i_en = 1'b0; step();
    i_ch_mask = '0; i_pulse = 10;
    n = cyc; i_en = 1'b1;
    wait_until(n + 250);
    n_checks++; if (o_ch_idx !== 2'd1) begin n_fail++; $display("FAIL mask0_ch_idx: got %0d, expected 1", o_ch_idx); end
    n_checks++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL mask0_busy: got %b, expected 0", o_busy); end
    i_en = 1'b0; step();
    i_ch_mask = 4'b1111; i_cycle = 0;
    n = cyc; i_en = 1'b1;
    wait_until(n + 300);
    i_en = 1'b0; step();
    n_checks++;
    if (st_q.size() + trig_q.size() + ovr_q.size() != 0) begin
      n_fail++; $display("FAIL edges_drain: pending %0d/%0d/%0d, expected 0/0/0", st_q.size(), trig_q.size(), ovr_q.size());
    end
    st_q.delete(); trig_q.delete(); ovr_q.delete();
  endtask

  task automatic test_reset_mid_wdelay();
    int n;
    i_cycle = 100; i_wavedelay = 50; i_pulse = 10; i_ch_mask = 4'b1111;
    n = cyc; i_en = 1'b1;
    push_st(n + 100, 2);
    wait_until(n + 120);
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b, expected 1", o_busy); end
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", o_busy); end
    n_checks++; if (o_ch_idx !== '0)   begin n_fail++; $display("FAIL midrst_ch_idx: got %0d, expected 0", o_ch_idx); end
    n_checks++; if (o_trig !== '0)     begin n_fail++; $display("FAIL midrst_trig: got %b, expected 0", o_trig); end
    n_checks++; if (o_st !== 1'b0)     begin n_fail++; $display("FAIL midrst_st: got %b, expected 0", o_st); end
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b, expected 0", o_overrun); end
    i_en = 1'b0;
    repeat (2) step();
    i_rst_n = 1'b1;
    repeat (3) step();
    n_checks++;
    if (st_q.size() + trig_q.size() + ovr_q.size() != 0) begin
      n_fail++; $display("FAIL midrst_drain: pending %0d/%0d/%0d, expected 0/0/0", st_q.size(), trig_q.size(), ovr_q.size());
    end
    st_q.delete(); trig_q.delete(); ovr_q.delete();
  endtask

  initial begin
    test_reset();
    test_internal();
    test_mask_alternate();
    test_external();
    test_overrun();
    test_abort();
    test_edges();
    test_reset_mid_wdelay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
